// File: rtl/auth_ctrl_pin_if.sv
// Byte handshake between the BLE UART receiver and the authorization controller.
//   rx_rdy     : UART -> ctrl, byte valid, held until clr_rx_rdy
//   rx_data    : UART -> ctrl, received byte
//   clr_rx_rdy : ctrl -> UART, one-cycle pulse, byte consumed
interface auth_ctrl_pin_if;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       clr_rx_rdy;

  modport master (output rx_rdy, output rx_data, input clr_rx_rdy);
  modport slave  (input rx_rdy, input rx_data, output clr_rx_rdy);
endinterface

// File: rtl/auth_ctrl_pin.sv
// Rider authorization controller: GO/STOP command bytes, optional PIN after GO,
// lockout after repeated bad PINs, GO heartbeat timeout, debounced rider_off.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   rx         : UART byte handshake (slave side)
//   rider_off  : raw rider-off from steer_en
//   pwr_up     : power authorized (PWR1 or PWR2)
//   locked     : high while in lockout
//   fail_cnt   : consecutive bad-PIN count
module auth_ctrl_pin #(
  parameter logic [7:0]  GO_CODE       = 8'h47,
  parameter logic [7:0]  STOP_CODE     = 8'h53,
  parameter int unsigned PIN_LEN       = 2,
  parameter logic [31:0] PIN           = 32'h0000_3137,
  parameter int unsigned MAX_FAIL      = 3,
  parameter int unsigned LOCK_CLKS     = 1000000,
  parameter int unsigned HB_CLKS       = 0,
  parameter int unsigned RIDER_DB_CLKS = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  auth_ctrl_pin_if.slave        rx,
  input  logic                  rider_off,
  output logic                  pwr_up,
  output logic                  locked,
  output logic [3:0]            fail_cnt
);

  localparam int unsigned LOCK_W   = $clog2(LOCK_CLKS + 1);
  localparam int unsigned HB_W     = (HB_CLKS > 0) ? $clog2(HB_CLKS + 1) : 1;
  localparam int unsigned DB_W     = $clog2(RIDER_DB_CLKS + 1);
  localparam int unsigned IDX_LAST = (PIN_LEN > 0) ? PIN_LEN - 1 : 0;

  typedef enum logic [2:0] {
    S_OFF  = 3'd0,
    S_PIN  = 3'd1,
    S_LOCK = 3'd2,
    S_PWR1 = 3'd3,
    S_PWR2 = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              clr_rx_rdy_q, clr_rx_rdy_d;
  logic              pwr_up_q, pwr_up_d;
  logic              locked_q, locked_d;
  logic [3:0]        fail_q, fail_d;
  logic [1:0]        idx_q, idx_d;
  logic [LOCK_W-1:0] lock_q, lock_d;
  logic [HB_W-1:0]   hb_q, hb_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              rider_off_db_q, rider_off_db_d;

  logic              byte_v;
  logic              is_go;
  logic              is_stop;
  logic [1:0]        pin_sel;
  logic              pin_hit;
  logic [3:0]        fail_inc;
  logic [HB_W-1:0]   hb_inc;
  logic              hb_expired;

  // A byte is taken only while no consume pulse is outstanding, so the
  // still-high rx_rdy during the pulse cycle is never evaluated twice.
  assign byte_v  = rx.rx_rdy & ~clr_rx_rdy_q;
  assign is_go   = byte_v && (rx.rx_data == GO_CODE);
  assign is_stop = byte_v && (rx.rx_data == STOP_CODE);

  // PIN is sent MSB byte first: index 0 selects the highest used byte.
  assign pin_sel = 2'(IDX_LAST) - idx_q;
  assign pin_hit = (rx.rx_data == PIN[{pin_sel, 3'b000} +: 8]);

  assign fail_inc   = (fail_q == 4'hF) ? fail_q : fail_q + 4'd1;
  assign hb_inc     = (hb_q == HB_W'(HB_CLKS)) ? hb_q : hb_q + HB_W'(1);
  assign hb_expired = (HB_CLKS != 0) && (hb_inc == HB_W'(HB_CLKS));

  // rider_off debounce: saturating run-length of consecutive high samples.
  always_comb begin
    db_cnt_d       = '0;
    rider_off_db_d = 1'b0;
    if (rider_off) begin
      db_cnt_d       = (db_cnt_q == DB_W'(RIDER_DB_CLKS)) ? db_cnt_q : db_cnt_q + DB_W'(1);
      rider_off_db_d = (db_cnt_d == DB_W'(RIDER_DB_CLKS));
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fail_d  = fail_q;
    lock_d  = '0;
    hb_d    = '0;

    unique case (state_q)
      S_OFF: begin
        if (is_go) begin
          idx_d   = '0;
          state_d = (PIN_LEN == 0) ? S_PWR1 : S_PIN;
        end
      end

      // GO_CODE is plain data here.
      S_PIN: begin
        if (byte_v) begin
          if (pin_hit) begin
            if (idx_q == 2'(IDX_LAST)) begin
              state_d = S_PWR1;
              fail_d  = '0;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end else begin
            fail_d  = fail_inc;
            idx_d   = '0;
            state_d = (fail_inc == 4'(MAX_FAIL)) ? S_LOCK : S_OFF;
          end
        end
      end

      S_LOCK: begin
        if (lock_q == LOCK_W'(LOCK_CLKS - 1)) begin
          state_d = S_OFF;
          fail_d  = '0;
        end else begin
          lock_d = lock_q + LOCK_W'(1);
        end
      end

      // STOP outranks a coincident heartbeat expiry; GO refreshes the heartbeat.
      S_PWR1: begin
        if (is_stop) begin
          state_d = rider_off_db_q ? S_OFF : S_PWR2;
        end else if (is_go) begin
          hb_d = '0;
        end else if (hb_expired) begin
          state_d = S_PWR2;
        end else begin
          hb_d = hb_inc;
        end
      end

      S_PWR2: begin
        if (rider_off_db_q) begin
          state_d = S_OFF;
        end else if (is_go) begin
          state_d = S_PWR1;
        end
      end

      default: state_d = S_OFF;
    endcase

    clr_rx_rdy_d = byte_v;
    pwr_up_d     = (state_d == S_PWR1) || (state_d == S_PWR2);
    locked_d     = (state_d == S_LOCK);
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_OFF;
      clr_rx_rdy_q   <= 1'b0;
      pwr_up_q       <= 1'b0;
      locked_q       <= 1'b0;
      fail_q         <= '0;
      idx_q          <= '0;
      lock_q         <= '0;
      hb_q           <= '0;
      db_cnt_q       <= '0;
      rider_off_db_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      clr_rx_rdy_q   <= clr_rx_rdy_d;
      pwr_up_q       <= pwr_up_d;
      locked_q       <= locked_d;
      fail_q         <= fail_d;
      idx_q          <= idx_d;
      lock_q         <= lock_d;
      hb_q           <= hb_d;
      db_cnt_q       <= db_cnt_d;
      rider_off_db_q <= rider_off_db_d;
    end
  end

  assign rx.clr_rx_rdy = clr_rx_rdy_q;
  assign pwr_up        = pwr_up_q;
  assign locked        = locked_q;
  assign fail_cnt      = fail_q;

endmodule

// File: tb/tb_auth_ctrl_pin.sv
// Directed bench for auth_ctrl_pin with shortened lock/heartbeat/debounce
// times. Inputs change and outputs are sampled on the falling clock edge.
module tb_auth_ctrl_pin;

  localparam int unsigned T_LOCK = 20;
  localparam int unsigned T_HB   = 50;
  localparam int unsigned T_DB   = 8;

  localparam logic [7:0] C_G = 8'h47;
  localparam logic [7:0] C_S = 8'h53;
  localparam logic [7:0] C_1 = 8'h31;
  localparam logic [7:0] C_2 = 8'h32;
  localparam logic [7:0] C_7 = 8'h37;
  localparam logic [7:0] C_8 = 8'h38;

  logic       clk = 1'b0;
  logic       rst;
  logic       rider_off;
  logic       pwr_up;
  logic       locked;
  logic [3:0] fail_cnt;
  logic       pw;
  int         total = 0;
  int         bad   = 0;

  auth_ctrl_pin_if bus ();

  auth_ctrl_pin #(
    .GO_CODE      (8'h47),
    .STOP_CODE    (8'h53),
    .PIN_LEN      (2),
    .PIN          (32'h0000_3137),
    .MAX_FAIL     (3),
    .LOCK_CLKS    (T_LOCK),
    .HB_CLKS      (T_HB),
    .RIDER_DB_CLKS(T_DB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (bus),
    .rider_off(rider_off),
    .pwr_up   (pwr_up),
    .locked   (locked),
    .fail_cnt (fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Present one byte; pw_eval is pwr_up right after the evaluating edge.
  task automatic send(input logic [7:0] b, output logic pw_eval);
    bus.rx_rdy  = 1'b1;
    bus.rx_data = b;
    step(1);
    chk("clr_pulse", 32'(bus.clr_rx_rdy), 32'd1);
    pw_eval = pwr_up;
    bus.rx_rdy = 1'b0;
    step(1);
    chk("clr_single", 32'(bus.clr_rx_rdy), 32'd0);
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       output logic pw_eval);
    logic p;
    send(a, p);
    send(b, p);
    send(c, pw_eval);
  endtask

  initial begin
    rst         = 1'b1;
    rider_off   = 1'b0;
    bus.rx_rdy  = 1'b0;
    bus.rx_data = 8'h00;
    step(2);
    chk("rst_pwr", 32'(pwr_up), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_fail", 32'(fail_cnt), 32'd0);
    chk("rst_clr", 32'(bus.clr_rx_rdy), 32'd0);
    rst = 1'b0;
    step(1);

    // Authorize with the correct PIN.
    send(C_G, pw);
    chk("t1_pin_after_g", 32'(pwr_up), 32'd0);
    send(C_1, pw);
    chk("t1_pin_after_1", 32'(pwr_up), 32'd0);
    send(C_7, pw);
    chk("t1_pwr_eval", 32'(pw), 32'd1);
    chk("t1_fail", 32'(fail_cnt), 32'd0);

    // STOP with rider on -> PWR2; then rider_off drops power after T_DB+1 clocks.
    send(C_S, pw);
    chk("t3_pwr2", 32'(pw), 32'd1);
    rider_off = 1'b1;
    step(T_DB);
    chk("t3_pwr_db_edge", 32'(pwr_up), 32'd1);
    step(1);
    chk("t3_pwr_off", 32'(pwr_up), 32'd0);
    rider_off = 1'b0;

    // Short rider_off glitch in PWR2 is ignored; GO returns to PWR1 without PIN.
    send3(C_G, C_1, C_7, pw);
    chk("t4_auth", 32'(pw), 32'd1);
    send(C_S, pw);
    chk("t4_pwr2", 32'(pw), 32'd1);
    rider_off = 1'b1;
    step(T_DB - 1);
    rider_off = 1'b0;
    step(3);
    chk("t4_glitch", 32'(pwr_up), 32'd1);
    send(C_G, pw);
    chk("t4_go_pwr1", 32'(pw), 32'd1);
    rider_off = 1'b1;
    step(12);
    chk("t4_pwr1_ignores_db", 32'(pwr_up), 32'd1);
    send(C_S, pw);
    chk("t4_stop_db_off", 32'(pw), 32'd0);

    // Heartbeat: GO refreshes keep PWR1; expiry -> PWR2, then debounced rider_off -> OFF.
    send3(C_G, C_1, C_7, pw);
    chk("t5_auth", 32'(pw), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(37);
      send(C_G, pw);
      chk("t5_refresh", 32'(pw), 32'd1);
    end
    step(T_HB - 1);
    chk("t5_before_off", 32'(pwr_up), 32'd1);
    step(1);
    chk("t5_expired_off", 32'(pwr_up), 32'd0);

    // STOP coincident with heartbeat expiry is a STOP (rider off -> OFF at once).
    send3(C_G, C_1, C_7, pw);
    chk("t5b_auth", 32'(pw), 32'd1);
    step(T_HB - 2);
    send(C_S, pw);
    chk("t5b_stop_wins", 32'(pw), 32'd0);
    rider_off = 1'b0;
    step(2);

    // Bad PIN bumps fail_cnt; good PIN clears it.
    send(C_G, pw);
    send(C_2, pw);
    chk("t2_fail_first_byte", 32'(fail_cnt), 32'd1);
    send3(C_G, C_1, C_7, pw);
    chk("t2_auth_after_bad", 32'(pw), 32'd1);
    chk("t2_fail_cleared", 32'(fail_cnt), 32'd0);
    send(C_S, pw);
    rider_off = 1'b1;
    step(T_DB + 1);
    chk("t2_off", 32'(pwr_up), 32'd0);
    rider_off = 1'b0;
    step(1);

    // Lockout after three bad PINs; bytes during LOCK are consumed and ignored.
    send3(C_G, C_1, C_8, pw);
    chk("t2_fail1", 32'(fail_cnt), 32'd1);
    chk("t2_nolock1", 32'(locked), 32'd0);
    send3(C_G, C_1, C_8, pw);
    chk("t2_fail2", 32'(fail_cnt), 32'd2);
    send3(C_G, C_1, C_8, pw);
    chk("t2_fail3", 32'(fail_cnt), 32'd3);
    chk("t2_locked", 32'(locked), 32'd1);
    send3(C_G, C_1, C_7, pw);
    chk("t2_lock_ignores", 32'(pw), 32'd0);
    chk("t2_still_locked", 32'(locked), 32'd1);
    chk("t2_fail_held", 32'(fail_cnt), 32'd3);
    step(T_LOCK - 8);
    chk("t2_lock_last", 32'(locked), 32'd1);
    step(1);
    chk("t2_unlocked", 32'(locked), 32'd0);
    chk("t2_fail_reset", 32'(fail_cnt), 32'd0);

    // Reset in PIN idx=1, in LOCK, and in PWR1.
    send(C_G, pw);
    send(C_1, pw);
    rst = 1'b1;
    step(1);
    chk("t6_pin_rst_pwr", 32'(pwr_up), 32'd0);
    chk("t6_pin_rst_clr", 32'(bus.clr_rx_rdy), 32'd0);
    rst = 1'b0;
    send(C_7, pw);
    chk("t6_idx_cleared", 32'(pw), 32'd0);
    send3(C_G, C_1, C_8, pw);
    send3(C_G, C_1, C_8, pw);
    send3(C_G, C_1, C_8, pw);
    chk("t6_locked", 32'(locked), 32'd1);
    rst = 1'b1;
    step(1);
    chk("t6_lock_rst_locked", 32'(locked), 32'd0);
    chk("t6_lock_rst_fail", 32'(fail_cnt), 32'd0);
    chk("t6_lock_rst_pwr", 32'(pwr_up), 32'd0);
    rst = 1'b0;
    send3(C_G, C_1, C_7, pw);
    chk("t6_reauth", 32'(pw), 32'd1);
    chk("t6_reauth_fail", 32'(fail_cnt), 32'd0);
    rst = 1'b1;
    step(1);
    chk("t6_pwr_rst", 32'(pwr_up), 32'd0);
    rst = 1'b0;
    step(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
